// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle for fifo_sync_flags: write/read handshakes, data and status flags.
interface fifo_sync_flags_if #(
    parameter int DEPTH_BITS = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, almost flags, error pulses, flush and optional FWFT read.
module fifo_sync_flags #(
    parameter int DEPTH_BITS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input logic          clk,
    input logic          rst_n,
    fifo_sync_flags_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_AF   = (DEPTH_BITS+1)'(AFULL_THRESH);
    localparam logic [DEPTH_BITS:0]   CNT_AE   = (DEPTH_BITS+1)'(AEMPTY_THRESH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;

    generate
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("fifo_sync_flags: AFULL_THRESH out of range 1..DEPTH");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
            $error("fifo_sync_flags: AEMPTY_THRESH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_BITS:0]   count_q, count_next;
    logic                  full_w, empty_w, wr_acc, rd_acc;
    logic                  ovf_q, udf_q;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    // Flush wins over both requests in the same cycle.
    assign wr_acc  = bus.wr_en & ~full_w  & ~bus.clear;
    assign rd_acc  = bus.rd_en & ~empty_w & ~bus.clear;

    always_comb begin
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + CNT_ONE;
            2'b01:   count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            count_q <= count_next;
            ovf_q   <= bus.wr_en & full_w;
            udf_q   <= bus.rd_en & empty_w;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is presented combinationally; forced to zero while empty so reset reads 0.
            assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr];
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule
